vend_ctrl_multi: RTL and testbench

- Parametrised vending controller core for the candy machine: N products, two coin denominations, credit accumulation, vend handshake with timeout refund, and a unit-by-unit change dispensing sequencer.
- Sits between the keypad/coin decode front end and the dispenser/display back end.
- Replaces the fixed single-product candy flow with a generalised multi-item engine.

---
 rtl/vend_ctrl_multi.sv | 164 ++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit accumulation, lowest-index item
// selection, vend handshake with timeout refund and token-by-token change payout.
module vend_ctrl_multi #(
  parameter int NUM_ITEMS    = 5,
  parameter int PRICE_STEP   = 50,
  parameter int COIN_LO      = 50,
  parameter int COIN_HI      = 100,
  parameter int CHANGE_UNIT  = 50,
  parameter int MAX_CREDIT   = 250,
  parameter int CREDIT_W     = 9,
  parameter int VEND_TIMEOUT = 16,
  localparam int IDX_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 coin_valid,
  input  logic                 coin_sel,
  input  logic [NUM_ITEMS-1:0] item_req,
  input  logic                 cancel,
  input  logic                 dispense_done,
  input  logic                 change_ack,
  output logic [CREDIT_W-1:0]  credit,
  output logic [NUM_ITEMS-1:0] can_buy,
  output logic                 vend_valid,
  output logic [IDX_W-1:0]     vend_item,
  output logic                 change_req,
  output logic                 coin_reject,
  output logic                 req_reject,
  output logic                 vend_fault
);

  localparam int CNT_W = (VEND_TIMEOUT > 1) ? $clog2(VEND_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      item_q, item_d;
  logic                  coin_rej_q, coin_rej_d;
  logic                  req_rej_q, req_rej_d;
  logic                  fault_q, fault_d;

  logic [NUM_ITEMS-1:0][CREDIT_W-1:0] price;
  logic                  shop_open;
  logic                  req_any;
  logic [IDX_W-1:0]      req_idx;
  logic [CREDIT_W-1:0]   req_price;
  logic [CREDIT_W-1:0]   vend_price;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;

  assign shop_open = (state_q == S_IDLE) || (state_q == S_CREDIT);

  // Price table and affordability, one comparator per product.
  for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_item
    assign price[g]   = CREDIT_W'((g + 1) * PRICE_STEP);
    assign can_buy[g] = shop_open && (credit_q >= price[g]);
  end

  // Lowest set request bit wins.
  always_comb begin
    req_idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--)
      if (item_req[i]) req_idx = IDX_W'(i);
  end

  assign req_any    = |item_req;
  assign req_price  = price[req_idx];
  assign vend_price = price[item_q];
  assign coin_val   = coin_sel ? CREDIT_W'(COIN_HI) : CREDIT_W'(COIN_LO);
  assign coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cnt_d      = cnt_q;
    item_d     = item_q;
    coin_rej_d = 1'b0;
    req_rej_d  = 1'b0;
    fault_d    = 1'b0;
    unique case (state_q)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          coin_rej_d = coin_valid;
          if (state_q == S_CREDIT) state_d = S_CHANGE;
        end else if (req_any) begin
          coin_rej_d = coin_valid;
          if (credit_q >= req_price) begin
            credit_d = credit_q - req_price;
            item_d   = req_idx;
            cnt_d    = '0;
            state_d  = S_VEND;
          end else begin
            req_rej_d = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_sum > (CREDIT_W + 1)'(MAX_CREDIT)) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = S_CREDIT;
          end
        end
      end
      S_VEND: begin
        coin_rej_d = coin_valid;
        if (dispense_done) begin
          state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
        end else if (cnt_q == CNT_W'(VEND_TIMEOUT - 1)) begin
          // Dispenser never answered: hand the price back as change.
          fault_d  = 1'b1;
          credit_d = credit_q + vend_price;
          state_d  = S_CHANGE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CHANGE: begin
        coin_rej_d = coin_valid;
        if (credit_q == '0) begin
          state_d = S_IDLE;
        end else if (change_ack) begin
          if (credit_q <= CREDIT_W'(CHANGE_UNIT)) begin
            credit_d = '0;
            state_d  = S_IDLE;
          end else begin
            credit_d = credit_q - CREDIT_W'(CHANGE_UNIT);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      credit_q   <= '0;
      cnt_q      <= '0;
      item_q     <= '0;
      coin_rej_q <= 1'b0;
      req_rej_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      item_q     <= item_d;
      coin_rej_q <= coin_rej_d;
      req_rej_q  <= req_rej_d;
      fault_q    <= fault_d;
    end
  end

  assign credit      = credit_q;
  assign vend_valid  = (state_q == S_VEND);
  assign vend_item   = item_q;
  assign change_req  = (state_q == S_CHANGE);
  assign coin_reject = coin_rej_q;
  assign req_reject  = req_rej_q;
  assign vend_fault  = fault_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Vector-table and scoreboard bench for vend_ctrl_multi with default parameters.
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid, coin_sel, cancel, dispense_done, change_ack;
  logic [4:0] item_req;
  logic [8:0] credit;
  logic [4:0] can_buy;
  logic       vend_valid;
  logic [2:0] vend_item;
  logic       change_req, coin_reject, req_reject, vend_fault;

  int total = 0;
  int bad   = 0;

  vend_ctrl_multi dut (
    .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_sel(coin_sel),
    .item_req(item_req), .cancel(cancel), .dispense_done(dispense_done),
    .change_ack(change_ack), .credit(credit), .can_buy(can_buy),
    .vend_valid(vend_valid), .vend_item(vend_item), .change_req(change_req),
    .coin_reject(coin_reject), .req_reject(req_reject), .vend_fault(vend_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] cr;
    logic [4:0] cb;
    logic       vv;
    logic [2:0] vi;
    logic       ch, crj, rrj, flt;
  } exp_t;

  typedef struct {
    logic       cv, cs;
    logic [4:0] req;
    logic       cn, dn, ak;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic cv, input logic cs, input logic [4:0] req,
                              input logic cn, input logic dn, input logic ak,
                              input logic [8:0] cr, input logic [4:0] cb, input logic vv,
                              input logic [2:0] vi, input logic ch, input logic crj,
                              input logic rrj, input logic flt);
    vec_t v;
    v.cv = cv; v.cs = cs; v.req = req; v.cn = cn; v.dn = dn; v.ak = ak;
    v.e.cr = cr; v.e.cb = cb; v.e.vv = vv; v.e.vi = vi;
    v.e.ch = ch; v.e.crj = crj; v.e.rrj = rrj; v.e.flt = flt;
    return v;
  endfunction

  task automatic check(input string name, input exp_t e);
    total++;
    if (credit !== e.cr || can_buy !== e.cb || vend_valid !== e.vv || vend_item !== e.vi ||
        change_req !== e.ch || coin_reject !== e.crj || req_reject !== e.rrj ||
        vend_fault !== e.flt) begin
      bad++;
      $display("FAIL %s: got cr=%0d cb=%b vv=%b vi=%0d ch=%b crj=%b rrj=%b flt=%b, want cr=%0d cb=%b vv=%b vi=%0d ch=%b crj=%b rrj=%b flt=%b",
               name, credit, can_buy, vend_valid, vend_item, change_req, coin_reject,
               req_reject, vend_fault, e.cr, e.cb, e.vv, e.vi, e.ch, e.crj, e.rrj, e.flt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(input string name, input vec_t v);
    exp_t got_e;
    coin_valid = v.cv; coin_sel = v.cs; item_req = v.req;
    cancel = v.cn; dispense_done = v.dn; change_ack = v.ak;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    got_e = sb.pop_front();
    check(name, got_e);
    coin_valid = 0; coin_sel = 0; item_req = '0; cancel = 0; dispense_done = 0; change_ack = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t rst_e;
    reset = 1; coin_valid = 0; coin_sel = 0; item_req = '0;
    cancel = 0; dispense_done = 0; change_ack = 0;

    // Main table: cv cs req cn dn ak | cr cb vv vi ch crj rrj flt
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,5'b00000,0,0,0, 150,5'b00111,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00100,0,0,0,   0,5'b00000,1,2,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,1,0,   0,5'b00000,0,2,0,0,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,2,0,0,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 200,5'b01111,0,2,0,0,0,0));
    vecs.push_back(mk(1,0,5'b00011,0,0,0, 150,5'b00000,1,0,0,1,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,0, 150,5'b00000,1,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,1,0, 150,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1, 100,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,0, 100,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,  50,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,   0,5'b00000,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 200,5'b01111,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 200,5'b01111,0,0,0,1,0,0));
    vecs.push_back(mk(1,0,5'b00000,1,0,0, 200,5'b00000,0,0,1,1,0,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,1, 150,5'b00000,0,0,1,1,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1, 100,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00001,0,0,1,  50,5'b00000,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,   0,5'b00000,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,   0,5'b00000,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,1,0,0,   0,5'b00000,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00001,0,0,0,   0,5'b00000,0,0,0,0,1,0));
    vecs.push_back(mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,0,0,0,0,0));
    vecs.push_back(mk(0,0,5'b10000,0,0,0, 100,5'b00011,0,0,0,0,1,0));
    vecs.push_back(mk(0,0,5'b00010,0,0,0,   0,5'b00000,1,1,0,0,0,0));
    vecs.push_back(mk(1,0,5'b00000,0,0,0,   0,5'b00000,1,1,0,1,0,0));
    for (int i = 0; i < 14; i++)
      vecs.push_back(mk(0,0,5'b00000,0,0,0, 0,5'b00000,1,1,0,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,0, 100,5'b00000,0,1,1,0,0,1));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,  50,5'b00000,0,1,1,0,0,0));
    vecs.push_back(mk(0,0,5'b00000,0,0,1,   0,5'b00000,0,1,0,0,0,0));

    repeat (2) @(posedge clk);
    #1;
    rst_e = '{cr:0, cb:0, vv:0, vi:0, ch:0, crj:0, rrj:0, flt:0};
    check("reset_state", rst_e);
    reset = 0;

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i]);

    // Done arriving on the very cycle the timeout would fire: no fault, no refund.
    step("to_coin",  mk(1,0,5'b00000,0,0,0, 50,5'b00001,0,1,0,0,0,0));
    step("to_req",   mk(0,0,5'b00001,0,0,0,  0,5'b00000,1,0,0,0,0,0));
    for (int i = 0; i < 15; i++)
      step($sformatf("to_wait%0d", i), mk(0,0,5'b00000,0,0,0, 0,5'b00000,1,0,0,0,0,0));
    step("to_done_wins", mk(0,0,5'b00000,0,1,0, 0,5'b00000,0,0,0,0,0,0));

    // Credit exactly at the ceiling is accepted; one more coin is not.
    step("max_c1",   mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,0,0,0,0,0));
    step("max_c2",   mk(1,1,5'b00000,0,0,0, 200,5'b01111,0,0,0,0,0,0));
    step("max_c3",   mk(1,0,5'b00000,0,0,0, 250,5'b11111,0,0,0,0,0,0));
    step("max_over", mk(1,0,5'b00000,0,0,0, 250,5'b11111,0,0,0,1,0,0));
    step("max_buy4", mk(0,0,5'b10000,0,0,0,   0,5'b00000,1,4,0,0,0,0));
    step("max_done", mk(0,0,5'b00000,0,1,0,   0,5'b00000,0,4,0,0,0,0));

    // Asynchronous reset in the middle of a change payout.
    step("rst_coin",   mk(1,1,5'b00000,0,0,0, 100,5'b00011,0,4,0,0,0,0));
    step("rst_cancel", mk(0,0,5'b00000,1,0,0, 100,5'b00000,0,4,1,0,0,0));
    #2;
    reset = 1;
    #1;
    check("rst_async", rst_e);
    @(posedge clk);
    #1;
    reset = 0;
    step("rst_after", mk(1,0,5'b00000,0,0,0, 50,5'b00001,0,0,0,0,0,0));

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
